// File: rtl/alu_sequencer.sv
// Purpose : issue-side controller for alu_core; runs one ALU op, applies 8051 PSW rules, returns ACC/B/PSW.
// Latency : wb_valid high in the cycle after the 3rd edge past accept (5th for SUBB with borrow in).
// Backpr. : req_ready only in IDLE; one op in flight, req_valid ignored while busy.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_op/req_src1/req_src2/psw_in latched on accept
//   alu_opcode, op_in_1/2,        registered drive into alu_core
//   carry_in, aux_carry_in
//   alu_res1/2, alu_cy/ac/ov      registered results coming back from alu_core
//   wb_valid, wb_acc, wb_b,       one-cycle write-back strobe with ACC/B data, B enable and new PSW
//   wb_b_en, psw_out
//   busy                          high whenever the FSM is not in IDLE

module alu_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_src1,
    input  logic [7:0] req_src2,
    input  logic [7:0] psw_in,
    output logic [3:0] alu_opcode,
    output logic [7:0] op_in_1,
    output logic [7:0] op_in_2,
    output logic       carry_in,
    output logic       aux_carry_in,
    input  logic [7:0] alu_res1,
    input  logic [7:0] alu_res2,
    input  logic       alu_cy,
    input  logic       alu_ac,
    input  logic       alu_ov,
    output logic       wb_valid,
    output logic [7:0] wb_acc,
    output logic [7:0] wb_b,
    output logic       wb_b_en,
    output logic [7:0] psw_out,
    output logic       busy
);

    // Opcode values mirror the ALU_* macros of 8051_define.v; keep in sync with the core.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDC = 4'h1;
    localparam logic [3:0] ALU_SUBB = 4'h2;
    localparam logic [3:0] ALU_DEC  = 4'h4;
    localparam logic [3:0] ALU_MUL  = 4'h5;
    localparam logic [3:0] ALU_DIV  = 4'h6;
    localparam logic [3:0] ALU_DA   = 4'h7;
    localparam logic [3:0] ALU_RLC  = 4'hD;
    localparam logic [3:0] ALU_RRC  = 4'hE;
    localparam logic [3:0] ALU_SWAP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ISSUE2,
        S_WAIT2,
        S_WB
    } state_t;

    state_t     state;

    // Request latched on accept.
    logic [3:0] op_q;
    logic [7:0] src1_q;
    logic [7:0] src2_q;
    logic [7:0] psw_q;

    // Captured core results. For two-pass SUBB, cy_q/ac_q already hold the final flags
    // after pass 1 and res1_q is overwritten by the decremented value.
    logic [7:0] res1_q;
    logic [7:0] res2_q;
    logic       cy_q;
    logic       ac_q;

    // Write-back values computed from the captured state, registered in WB.
    logic [7:0] nxt_acc;
    logic [7:0] nxt_b;
    logic       nxt_b_en;
    logic       nxt_cy;
    logic       nxt_ac;
    logic       nxt_ov;

    // Core OV is never used (OV is recomputed here) and the incoming P bit is always regenerated.
    logic       ignored_unused;
    assign ignored_unused = alu_ov ^ psw_q[0];

    always_comb begin
        nxt_acc  = res1_q;
        nxt_b    = res2_q;
        nxt_b_en = 1'b0;
        nxt_cy   = psw_q[7];
        nxt_ac   = psw_q[6];
        nxt_ov   = psw_q[2];
        case (op_q)
            ALU_ADD, ALU_ADDC: begin
                nxt_cy = cy_q;
                nxt_ac = ac_q;
                nxt_ov = (src1_q[7] ~^ src2_q[7]) & (src1_q[7] ^ res1_q[7]);
            end
            ALU_SUBB: begin
                nxt_cy = cy_q;
                nxt_ac = ac_q;
                nxt_ov = (src1_q[7] ^ src2_q[7]) & (src1_q[7] ^ res1_q[7]);
            end
            ALU_MUL: begin
                nxt_b_en = 1'b1;
                nxt_cy   = 1'b0;
                nxt_ov   = (res2_q != 8'h00);
            end
            ALU_DIV: begin
                nxt_b_en = 1'b1;
                nxt_cy   = 1'b0;
                if (src2_q == 8'h00) begin
                    // Divide by zero: operands are returned untouched, core output discarded.
                    nxt_acc = src1_q;
                    nxt_b   = src2_q;
                    nxt_ov  = 1'b1;
                end else begin
                    nxt_ov  = 1'b0;
                end
            end
            ALU_RLC, ALU_RRC: begin
                nxt_cy = cy_q;
            end
            ALU_DA: begin
                nxt_cy = psw_q[7] | (src1_q[7:4] > 4'd9)
                       | ((src1_q[7:4] == 4'd9) & (src1_q[3:0] > 4'd9));
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            op_q         <= ALU_SWAP;
            src1_q       <= 8'h00;
            src2_q       <= 8'h00;
            psw_q        <= 8'h00;
            res1_q       <= 8'h00;
            res2_q       <= 8'h00;
            cy_q         <= 1'b0;
            ac_q         <= 1'b0;
            alu_opcode   <= ALU_SWAP;
            op_in_1      <= 8'h00;
            op_in_2      <= 8'h00;
            carry_in     <= 1'b0;
            aux_carry_in <= 1'b0;
            wb_valid     <= 1'b0;
            wb_acc       <= 8'h00;
            wb_b         <= 8'h00;
            wb_b_en      <= 1'b0;
            psw_out      <= 8'h00;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q         <= req_op;
                        src1_q       <= req_src1;
                        src2_q       <= req_src2;
                        psw_q        <= psw_in;
                        alu_opcode   <= req_op;
                        op_in_1      <= req_src1;
                        op_in_2      <= req_src2;
                        carry_in     <= psw_in[7];
                        aux_carry_in <= psw_in[6];
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    res1_q <= alu_res1;
                    res2_q <= alu_res2;
                    if ((op_q == ALU_SUBB) && psw_q[7]) begin
                        // Borrow in: decrement the pass-1 difference. A zero difference
                        // (or zero low nibble) borrows again.
                        cy_q       <= alu_cy | (alu_res1 == 8'h00);
                        ac_q       <= alu_ac | (alu_res1[3:0] == 4'h0);
                        alu_opcode <= ALU_DEC;
                        op_in_1    <= alu_res1;
                        op_in_2    <= 8'h00;
                        state      <= S_ISSUE2;
                    end else begin
                        cy_q       <= alu_cy;
                        ac_q       <= alu_ac;
                        alu_opcode <= ALU_SWAP;
                        op_in_1    <= 8'h00;
                        op_in_2    <= 8'h00;
                        state      <= S_WB;
                    end
                end
                S_ISSUE2: begin
                    state <= S_WAIT2;
                end
                S_WAIT2: begin
                    res1_q     <= alu_res1;
                    alu_opcode <= ALU_SWAP;
                    op_in_1    <= 8'h00;
                    op_in_2    <= 8'h00;
                    state      <= S_WB;
                end
                S_WB: begin
                    wb_valid  <= 1'b1;
                    wb_acc    <= nxt_acc;
                    wb_b      <= nxt_b;
                    wb_b_en   <= nxt_b_en;
                    psw_out   <= {nxt_cy, nxt_ac, psw_q[5:3], nxt_ov, psw_q[1], ^nxt_acc};
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
